ssemi_cic_decimator: RTL

Multi-stage CIC decimation filter that consumes the divided-rate strobe from the decimation clock divider. Integrators run at the input sample rate; the comb section runs once per decimation strobe (the divider's positive-edge pulse) and emits one full-precision decimated sample. It sits between the AFE/modulator sample stream and the downstream FIR/compensation stages.

---
 rtl/ssemi_cic_decimator_pkg.sv | 17 +
 rtl/ssemi_cic_decimator_if.sv | 23 ++
 rtl/ssemi_cic_integrator.sv | 17 +
 rtl/ssemi_cic_decimator.sv | 95 +++++++++
 4 files changed

// File: rtl/ssemi_cic_decimator_pkg.sv
// Shared limits and width helper for the CIC decimator slice.
// Global limits also exposed as macros so parameter defaults can use them.
`ifndef SSEMI_DEFINES_VH
`define SSEMI_DEFINES_VH
`define SSEMI_CIC_MAX_ORDER 6
`define SSEMI_DEC_MAX 64
`endif

package ssemi_cic_decimator_pkg;
  localparam int SSEMI_CIC_MAX_ORDER = `SSEMI_CIC_MAX_ORDER;
  localparam int SSEMI_DEC_MAX       = `SSEMI_DEC_MAX;

  // Full-precision CIC width: input width plus N*log2(R*M) bits of growth.
  function automatic int cic_acc_width(int dw, int n, int m, int max_dec);
    return dw + n * $clog2(max_dec * m);
  endfunction
endpackage

// File: rtl/ssemi_cic_decimator_if.sv
// Sample-stream bundle between the modulator front end and the CIC decimator.
interface ssemi_cic_decimator_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 34
);
  logic                         i_enable;
  logic                         i_sync_reset;
  logic                         i_valid;
  logic signed [DATA_WIDTH-1:0] i_data;
  logic                         i_dec_strobe;
  logic                         o_valid;
  logic signed [ACC_WIDTH-1:0]  o_data;
  logic                         o_settled;

  modport master (
    output i_enable, i_sync_reset, i_valid, i_data, i_dec_strobe,
    input  o_valid, o_data, o_settled
  );
  modport slave (
    input  i_enable, i_sync_reset, i_valid, i_data, i_dec_strobe,
    output o_valid, o_data, o_settled
  );
endinterface

// File: rtl/ssemi_cic_integrator.sv
// One CIC integrator stage: wrapping accumulator with hold and sync clear.
module ssemi_cic_integrator #(
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] acc
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + din;
  end
endmodule

// File: rtl/ssemi_cic_decimator.sv
// N-stage CIC decimator: integrators at input rate, comb chain once per
// decimation strobe, full-precision output one cycle after the strobe.
module ssemi_cic_decimator
  import ssemi_cic_decimator_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CIC_ORDER  = 3,
  parameter int DIFF_DELAY = 1,
  parameter int MAX_DEC    = `SSEMI_DEC_MAX
) (
  input logic i_clk,
  input logic i_rst_n,
  ssemi_cic_decimator_if.slave bus
);
  localparam int ACC_WIDTH = cic_acc_width(DATA_WIDTH, CIC_ORDER, DIFF_DELAY, MAX_DEC);
  localparam int SETTLE_N  = CIC_ORDER * DIFF_DELAY + 1;
  localparam int CW        = $clog2(SETTLE_N + 1);

  if (CIC_ORDER < 1 || CIC_ORDER > SSEMI_CIC_MAX_ORDER) begin : g_bad_order
    $error("ssemi_cic_decimator: CIC_ORDER %0d out of range", CIC_ORDER);
  end
  if (DIFF_DELAY < 1 || DIFF_DELAY > 2) begin : g_bad_delay
    $error("ssemi_cic_decimator: DIFF_DELAY %0d out of range", DIFF_DELAY);
  end

  logic                                         clr;
  logic [CIC_ORDER-1:0][ACC_WIDTH-1:0]          integ, integ_in;
  logic [ACC_WIDTH-1:0]                         cap;
  logic [CIC_ORDER-1:0][DIFF_DELAY-1:0][ACC_WIDTH-1:0] dly;
  logic [CIC_ORDER:0][ACC_WIDTH-1:0]            comb;
  logic [1:0]                                   vld_pipe;
  logic [ACC_WIDTH-1:0]                         data_q;
  logic [CW-1:0]                                settle_cnt;
  logic                                         settled;

  assign clr = ~bus.i_enable | bus.i_sync_reset;

  always_comb begin
    integ_in    = '0;
    integ_in[0] = ACC_WIDTH'(bus.i_data);
    for (int k = 1; k < CIC_ORDER; k++) integ_in[k] = integ[k-1];
  end

  for (genvar g = 0; g < CIC_ORDER; g++) begin : g_int
    ssemi_cic_integrator #(.WIDTH(ACC_WIDTH)) u_int (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .clr   (clr),
      .en    (bus.i_valid),
      .din   (integ_in[g]),
      .acc   (integ[g])
    );
  end

  // Comb chain evaluates the sample captured on the previous strobe edge.
  always_comb begin
    comb    = '0;
    comb[0] = cap;
    for (int k = 0; k < CIC_ORDER; k++) comb[k+1] = comb[k] - dly[k][DIFF_DELAY-1];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_pipe   <= '0;
      cap        <= '0;
      dly        <= '0;
      data_q     <= '0;
      settle_cnt <= '0;
      settled    <= 1'b0;
    end else if (clr) begin
      vld_pipe   <= '0;
      cap        <= '0;
      dly        <= '0;
      data_q     <= '0;
      settle_cnt <= '0;
      settled    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0], bus.i_dec_strobe};
      if (bus.i_dec_strobe) cap <= integ[CIC_ORDER-1];
      if (vld_pipe[0]) begin
        data_q <= comb[CIC_ORDER];
        for (int k = 0; k < CIC_ORDER; k++) begin
          dly[k][0] <= comb[k];
          for (int j = 1; j < DIFF_DELAY; j++) dly[k][j] <= dly[k][j-1];
        end
        if (settle_cnt != CW'(SETTLE_N)) settle_cnt <= settle_cnt + 1'b1;
        if (settle_cnt >= CW'(SETTLE_N - 1)) settled <= 1'b1;
      end
    end
  end

  assign bus.o_valid   = vld_pipe[1];
  assign bus.o_data    = data_q;
  assign bus.o_settled = settled;
endmodule
